// File: rtl/aib_calib_master_seq.sv
// Restartable AIB master calibration sequencer with watchdog and retries.
// Optional DONE-state link monitor is enabled by defining AIB_CALIB_LINK_MON_EN.
module aib_calib_master_seq #(
   parameter int unsigned TOTAL_CHNL_NUM  = 24,
   parameter int unsigned TIMEOUT_W       = 16,
   parameter int unsigned TIMEOUT_CYCLES  = 50000,
   parameter int unsigned MAX_RETRIES     = 3,
   parameter int unsigned RST_HOLD_CYCLES = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      abort,
   input  logic [TOTAL_CHNL_NUM-1:0] chnl_mask,
   output logic                      cfg_start,
   input  logic                      cfg_done,
   output logic                      phase_start,
   input  logic                      phase_done,
   output logic                      i_conf_done,
   output logic [TOTAL_CHNL_NUM-1:0] ns_mac_rdy,
   output logic [TOTAL_CHNL_NUM-1:0] ns_adapter_rstn,
   output logic [TOTAL_CHNL_NUM-1:0] ms_rx_dcc_dll_lock_req,
   output logic [TOTAL_CHNL_NUM-1:0] ms_tx_dcc_dll_lock_req,
   input  logic [TOTAL_CHNL_NUM-1:0] sl_tx_transfer_en,
   input  logic [TOTAL_CHNL_NUM-1:0] sl_rx_transfer_en,
   output logic                      calib_done,
   output logic                      calib_err,
   output logic [2:0]                err_code,
   output logic [1:0]                retry_cnt,
   output logic [3:0]                state_o
`ifdef AIB_CALIB_LINK_MON_EN
   ,
   output logic [7:0]                relock_cnt
`endif
);

   typedef enum logic [3:0] {
      IDLE       = 4'd0,
      RESET      = 4'd1,
      CFG_WAIT   = 4'd2,
      CONF_DONE  = 4'd3,
      PHASE_WAIT = 4'd4,
      ASSERT_RDY = 4'd5,
      LOCK_REQ   = 4'd6,
      XFER_WAIT  = 4'd7,
      DONE       = 4'd8,
      FAIL       = 4'd9
   } state_t;

   localparam logic [TIMEOUT_W-1:0] WD_LAST  = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TIMEOUT_W-1:0] RST_LAST = TIMEOUT_W'(RST_HOLD_CYCLES - 1);
   localparam logic [TIMEOUT_W-1:0] WD_ONE   = TIMEOUT_W'(1);

   state_t                    state;
   logic [TOTAL_CHNL_NUM-1:0] mask_q;
   logic [TIMEOUT_W-1:0]      wd_cnt;
   logic                      wait_st;
   logic                      wait_ok;
   logic [2:0]                wait_code;
   logic                      xfer_ok;
   logic                      tmo;
   logic                      relock;
   logic                      retry_evt;
   logic [2:0]                evt_code;
   logic                      can_retry;

   assign state_o = state;

   assign xfer_ok = ((sl_tx_transfer_en & mask_q) == mask_q) &&
                    ((sl_rx_transfer_en & mask_q) == mask_q);

   always_comb begin
      wait_st   = 1'b0;
      wait_ok   = 1'b0;
      wait_code = 3'd0;
      unique case (state)
         CFG_WAIT: begin
            wait_st   = 1'b1;
            wait_ok   = cfg_done;
            wait_code = 3'd1;
         end
         PHASE_WAIT: begin
            wait_st   = 1'b1;
            wait_ok   = phase_done;
            wait_code = 3'd2;
         end
         XFER_WAIT: begin
            wait_st   = 1'b1;
            wait_ok   = xfer_ok;
            wait_code = 3'd3;
         end
         default: ;
      endcase
   end

   // Completion beats a same-cycle watchdog expiry.
   assign tmo       = wait_st & ~wait_ok & (wd_cnt == WD_LAST);
   assign retry_evt = tmo | relock;
   assign evt_code  = relock ? 3'd3 : wait_code;
   // retry_cnt saturates at 3, which also caps the usable retry budget.
   assign can_retry = (32'(retry_cnt) < MAX_RETRIES) && (retry_cnt != 2'd3);

`ifdef AIB_CALIB_LINK_MON_EN
   logic drop;
   logic drop_q;

   assign drop   = (state == DONE) &&
                   (|(mask_q & ~(sl_tx_transfer_en & sl_rx_transfer_en)));
   assign relock = drop & drop_q & ~start;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_q     <= 1'b0;
         relock_cnt <= 8'd0;
      end else if (abort) begin
         drop_q     <= 1'b0;
         relock_cnt <= 8'd0;
      end else begin
         drop_q <= drop;
         if (relock && (relock_cnt != 8'hFF))
            relock_cnt <= relock_cnt + 8'd1;
      end
   end
`else
   assign relock = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                  <= IDLE;
         mask_q                 <= '0;
         wd_cnt                 <= '0;
         cfg_start              <= 1'b0;
         phase_start            <= 1'b0;
         i_conf_done            <= 1'b0;
         ns_mac_rdy             <= '0;
         ns_adapter_rstn        <= '0;
         ms_rx_dcc_dll_lock_req <= '0;
         ms_tx_dcc_dll_lock_req <= '0;
         calib_done             <= 1'b0;
         calib_err              <= 1'b0;
         err_code               <= 3'd0;
         retry_cnt              <= 2'd0;
      end else if (abort) begin
         state                  <= IDLE;
         mask_q                 <= '0;
         wd_cnt                 <= '0;
         cfg_start              <= 1'b0;
         phase_start            <= 1'b0;
         i_conf_done            <= 1'b0;
         ns_mac_rdy             <= '0;
         ns_adapter_rstn        <= '0;
         ms_rx_dcc_dll_lock_req <= '0;
         ms_tx_dcc_dll_lock_req <= '0;
         calib_done             <= 1'b0;
         calib_err              <= 1'b0;
         err_code               <= 3'd0;
         retry_cnt              <= 2'd0;
      end else begin
         cfg_start   <= 1'b0;
         phase_start <= 1'b0;
         if (retry_evt) begin
            wd_cnt                 <= '0;
            i_conf_done            <= 1'b0;
            ns_mac_rdy             <= '0;
            ns_adapter_rstn        <= '0;
            ms_rx_dcc_dll_lock_req <= '0;
            ms_tx_dcc_dll_lock_req <= '0;
            calib_done             <= 1'b0;
            if (can_retry) begin
               state     <= RESET;
               retry_cnt <= retry_cnt + 2'd1;
            end else begin
               state     <= FAIL;
               calib_err <= 1'b1;
               err_code  <= evt_code;
            end
         end else begin
            unique case (state)
               IDLE, DONE, FAIL: begin
                  if (start) begin
                     mask_q                 <= chnl_mask;
                     wd_cnt                 <= '0;
                     retry_cnt              <= 2'd0;
                     calib_done             <= 1'b0;
                     i_conf_done            <= 1'b0;
                     ns_mac_rdy             <= '0;
                     ns_adapter_rstn        <= '0;
                     ms_rx_dcc_dll_lock_req <= '0;
                     ms_tx_dcc_dll_lock_req <= '0;
                     if (chnl_mask == '0) begin
                        state     <= FAIL;
                        calib_err <= 1'b1;
                        err_code  <= 3'd4;
                     end else begin
                        state     <= RESET;
                        calib_err <= 1'b0;
                        err_code  <= 3'd0;
                     end
                  end
               end
               RESET: begin
                  if (wd_cnt == RST_LAST) begin
                     state           <= CFG_WAIT;
                     wd_cnt          <= '0;
                     cfg_start       <= 1'b1;
                     ns_adapter_rstn <= mask_q;
                  end else begin
                     wd_cnt <= wd_cnt + WD_ONE;
                  end
               end
               CFG_WAIT: begin
                  if (cfg_done) begin
                     state       <= CONF_DONE;
                     wd_cnt      <= '0;
                     i_conf_done <= 1'b1;
                  end else begin
                     wd_cnt <= wd_cnt + WD_ONE;
                  end
               end
               CONF_DONE: begin
                  state       <= PHASE_WAIT;
                  wd_cnt      <= '0;
                  phase_start <= 1'b1;
               end
               PHASE_WAIT: begin
                  if (phase_done) begin
                     state      <= ASSERT_RDY;
                     wd_cnt     <= '0;
                     ns_mac_rdy <= mask_q;
                  end else begin
                     wd_cnt <= wd_cnt + WD_ONE;
                  end
               end
               ASSERT_RDY: begin
                  state                  <= LOCK_REQ;
                  wd_cnt                 <= '0;
                  ms_rx_dcc_dll_lock_req <= mask_q;
                  ms_tx_dcc_dll_lock_req <= mask_q;
               end
               LOCK_REQ: begin
                  state  <= XFER_WAIT;
                  wd_cnt <= '0;
               end
               XFER_WAIT: begin
                  if (xfer_ok) begin
                     state      <= DONE;
                     wd_cnt     <= '0;
                     calib_done <= 1'b1;
                  end else begin
                     wd_cnt <= wd_cnt + WD_ONE;
                  end
               end
               default: begin
                  state  <= IDLE;
                  wd_cnt <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_aib_calib_master_seq.sv
// Self-checking bench for aib_calib_master_seq: scripted plan scenarios
// plus randomized runs against a state-level behavioural model.
module tb_aib_calib_master_seq;

   localparam int N    = 24;
   localparam int TO   = 100;
   localparam int MAXR = 2;
   localparam int HOLD = 8;
   localparam logic [N-1:0] ALL = {N{1'b1}};

   logic         clk = 1'b0;
   logic         rst, start, abort;
   logic [N-1:0] chnl_mask;
   logic         cfg_start, cfg_done, phase_start, phase_done;
   logic         i_conf_done;
   logic [N-1:0] ns_mac_rdy, ns_adapter_rstn;
   logic [N-1:0] ms_rx_dcc_dll_lock_req, ms_tx_dcc_dll_lock_req;
   logic [N-1:0] sl_tx_transfer_en, sl_rx_transfer_en;
   logic         calib_done, calib_err;
   logic [2:0]   err_code;
   logic [1:0]   retry_cnt;
   logic [3:0]   state_o;
`ifdef AIB_CALIB_LINK_MON_EN
   logic [7:0]   relock_cnt;
`endif

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   aib_calib_master_seq #(
      .TOTAL_CHNL_NUM(N), .TIMEOUT_W(16), .TIMEOUT_CYCLES(TO),
      .MAX_RETRIES(MAXR), .RST_HOLD_CYCLES(HOLD)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .chnl_mask(chnl_mask),
      .cfg_start(cfg_start), .cfg_done(cfg_done),
      .phase_start(phase_start), .phase_done(phase_done),
      .i_conf_done(i_conf_done), .ns_mac_rdy(ns_mac_rdy),
      .ns_adapter_rstn(ns_adapter_rstn),
      .ms_rx_dcc_dll_lock_req(ms_rx_dcc_dll_lock_req),
      .ms_tx_dcc_dll_lock_req(ms_tx_dcc_dll_lock_req),
      .sl_tx_transfer_en(sl_tx_transfer_en),
      .sl_rx_transfer_en(sl_rx_transfer_en),
      .calib_done(calib_done), .calib_err(calib_err),
      .err_code(err_code), .retry_cnt(retry_cnt), .state_o(state_o)
`ifdef AIB_CALIB_LINK_MON_EN
      , .relock_cnt(relock_cnt)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: phase number, cycles spent in it, and the run bookkeeping.
   int           m_st, m_age, m_err, m_rty, m_rl;
   logic [N-1:0] m_mask;
   bit           m_dp;

   always @(posedge clk) begin : model
      int st, age, err, rty, rl, code;
      logic [N-1:0] msk;
      bit ent, drop, fire, ok;
      if (rst) begin
         m_st <= 0; m_age <= 0; m_err <= 0; m_rty <= 0;
         m_rl <= 0; m_mask <= '0; m_dp <= 1'b0;
      end else begin
         st = m_st; age = m_age; err = m_err; rty = m_rty;
         rl = m_rl; msk = m_mask; ent = 0; fire = 0; code = 0;
         drop = (m_st == 8) && ((m_mask & ~(sl_tx_transfer_en & sl_rx_transfer_en)) != 0);
         if (abort) begin
            st = 0; msk = '0; err = 0; rty = 0; rl = 0; ent = 1; drop = 0;
         end else begin
            case (m_st)
               0, 8, 9: begin
                  if (start) begin
                     msk = chnl_mask; rty = 0; err = 0; ent = 1;
                     if (chnl_mask == '0) begin st = 9; err = 4; end
                     else st = 1;
                  end
`ifdef AIB_CALIB_LINK_MON_EN
                  else if (m_st == 8 && drop && m_dp) begin
                     if (rl < 255) rl++;
                     fire = 1; code = 3;
                  end
`endif
               end
               1: if (age == HOLD - 1) begin st = 2; ent = 1; end
               2: begin
                  if (cfg_done) begin st = 3; ent = 1; end
                  else if (age == TO - 1) begin fire = 1; code = 1; end
               end
               3: begin st = 4; ent = 1; end
               4: begin
                  if (phase_done) begin st = 5; ent = 1; end
                  else if (age == TO - 1) begin fire = 1; code = 2; end
               end
               5: begin st = 6; ent = 1; end
               6: begin st = 7; ent = 1; end
               7: begin
                  ok = ((sl_tx_transfer_en & msk) == msk) && ((sl_rx_transfer_en & msk) == msk);
                  if (ok) begin st = 8; ent = 1; end
                  else if (age == TO - 1) begin fire = 1; code = 3; end
               end
               default: begin st = 0; ent = 1; end
            endcase
            if (fire) begin
               ent = 1;
               if (rty < MAXR && rty < 3) begin rty++; st = 1; end
               else begin st = 9; err = code; end
            end
         end
         m_st <= st; m_age <= ent ? 0 : age + 1; m_err <= err;
         m_rty <= rty; m_rl <= rl; m_mask <= msk; m_dp <= drop;
      end
   end

   always @(negedge clk) begin : cmp
      logic [N-1:0] lo;
      if (!rst) begin
         lo = '0;
         chk("state_o", 32'(state_o), 32'(m_st));
         chk("ns_adapter_rstn", 32'(ns_adapter_rstn), 32'((m_st >= 2 && m_st <= 8) ? m_mask : lo));
         chk("i_conf_done", 32'(i_conf_done), 32'(m_st >= 3 && m_st <= 8));
         chk("ns_mac_rdy", 32'(ns_mac_rdy), 32'((m_st >= 5 && m_st <= 8) ? m_mask : lo));
         chk("rx_lock_req", 32'(ms_rx_dcc_dll_lock_req), 32'((m_st >= 6 && m_st <= 8) ? m_mask : lo));
         chk("tx_lock_req", 32'(ms_tx_dcc_dll_lock_req), 32'((m_st >= 6 && m_st <= 8) ? m_mask : lo));
         chk("cfg_start", 32'(cfg_start), 32'(m_st == 2 && m_age == 0));
         chk("phase_start", 32'(phase_start), 32'(m_st == 4 && m_age == 0));
         chk("calib_done", 32'(calib_done), 32'(m_st == 8));
         chk("calib_err", 32'(calib_err), 32'(m_st == 9));
         chk("err_code", 32'(err_code), 32'(m_err));
         chk("retry_cnt", 32'(retry_cnt), 32'(m_rty));
`ifdef AIB_CALIB_LINK_MON_EN
         chk("relock_cnt", 32'(relock_cnt), 32'(m_rl));
`endif
      end
   end

   task automatic pulse_start(input logic [N-1:0] m);
      @(negedge clk);
      chnl_mask = m;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_state(input int s, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (32'(state_o) == s) return;
      end
      n_chk++;
      n_err++;
      $display("FAIL wait_state: got state %0d required %0d after %0d cycles", state_o, s, budget);
   endtask

   task automatic pulse_cfg(input int dly);
      repeat (dly) @(negedge clk);
      cfg_done = 1'b1;
      @(negedge clk);
      cfg_done = 1'b0;
   endtask

   task automatic pulse_phase(input int dly);
      repeat (dly) @(negedge clk);
      phase_done = 1'b1;
      @(negedge clk);
      phase_done = 1'b0;
   endtask

   task automatic finish_flow(input int cdly, input int pdly);
      wait_state(2, 200);
      pulse_cfg(cdly);
      wait_state(4, 20);
      pulse_phase(pdly);
      wait_state(8, 200);
   endtask

   task automatic rand_run(input logic [N-1:0] m, input int budget);
      logic [N-1:0] r1, r2;
      pulse_start(m);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (state_o == 4'd8 || state_o == 4'd9) begin
            cfg_done = 0; phase_done = 0; abort = 0; start = 0;
            return;
         end
         r1 = N'($urandom());
         r2 = N'($urandom());
         cfg_done   = ($urandom_range(0, 99) < 3);
         phase_done = ($urandom_range(0, 99) < 3);
         abort      = ($urandom_range(0, 999) < 2);
         start      = ($urandom_range(0, 99) < 1);
         chnl_mask  = N'($urandom());
         if ($urandom_range(0, 99) < 6) begin
            sl_tx_transfer_en = m | r1;
            sl_rx_transfer_en = m | r2;
         end else begin
            sl_tx_transfer_en = r1;
            sl_rx_transfer_en = r2;
         end
      end
      cfg_done = 0; phase_done = 0; abort = 0; start = 0;
      n_chk++;
      n_err++;
      $display("FAIL rand_run: no DONE/FAIL within %0d cycles, state %0d", budget, state_o);
   endtask

   initial begin
      int pulses;
      logic [N-1:0] m;
      rst = 1'b1; start = 0; abort = 0; cfg_done = 0; phase_done = 0;
      chnl_mask = '0; sl_tx_transfer_en = '0; sl_rx_transfer_en = '0;
      repeat (3) @(negedge clk);
      chk("reset state_o", 32'(state_o), 0);
      chk("reset rstn", 32'(ns_adapter_rstn), 0);
      chk("reset calib_done", 32'(calib_done), 0);
      rst = 1'b0;

      // Full mask, slow config handshake.
      sl_tx_transfer_en = ALL; sl_rx_transfer_en = ALL;
      pulse_start(ALL);
      finish_flow(19, 9);
      chk("s1 calib_done", 32'(calib_done), 1);
      chk("s1 err_code", 32'(err_code), 0);
      chk("s1 retry_cnt", 32'(retry_cnt), 0);
      chk("s1 state_o", 32'(state_o), 8);
      chk("s1 mac_rdy", 32'(ns_mac_rdy), 32'h00FF_FFFF);

      // Sparse mask with only masked transfer enables.
      sl_tx_transfer_en = 24'h000005; sl_rx_transfer_en = 24'h000005;
      pulse_start(24'h000005);
      finish_flow(3, 2);
      chk("s2 rstn", 32'(ns_adapter_rstn), 32'h5);
      chk("s2 mac_rdy", 32'(ns_mac_rdy), 32'h5);
      chk("s2 lock_req", 32'(ms_tx_dcc_dll_lock_req), 32'h5);

      // Config never completes: initial try plus two retries.
      pulse_start(ALL);
      pulses = 0;
      for (int i = 0; i < 2000 && state_o != 4'd9; i++) begin
         @(negedge clk);
         if (cfg_start) pulses++;
      end
      chk("s3 cfg_start pulses", 32'(pulses), 3);
      chk("s3 retry_cnt", 32'(retry_cnt), 2);
      chk("s3 calib_err", 32'(calib_err), 1);
      chk("s3 err_code", 32'(err_code), 1);
      chk("s3 rstn", 32'(ns_adapter_rstn), 0);

      // cfg_done on the last watchdog cycle, then abort in XFER_WAIT.
      sl_tx_transfer_en = '0; sl_rx_transfer_en = '0;
      pulse_start(24'h0F0F0F);
      wait_state(2, 50);
      repeat (TO - 1) @(negedge clk);
      cfg_done = 1'b1;
      @(negedge clk);
      cfg_done = 1'b0;
      chk("s4 state after race", 32'(state_o), 3);
      chk("s4 retry_cnt", 32'(retry_cnt), 0);
      wait_state(4, 20);
      pulse_phase(1);
      wait_state(7, 20);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("s4 abort state", 32'(state_o), 0);
      chk("s4 abort rstn", 32'(ns_adapter_rstn), 0);
      chk("s4 abort i_conf_done", 32'(i_conf_done), 0);

      // Empty mask, then an ignored start during PHASE_WAIT.
      pulse_start('0);
      @(negedge clk);
      chk("s5 empty state", 32'(state_o), 9);
      chk("s5 empty err_code", 32'(err_code), 4);
      pulse_start(24'h00A0C0);
      wait_state(2, 50);
      pulse_cfg(2);
      wait_state(4, 20);
      pulse_start(24'h000001);
      chk("s5 ignored state", 32'(state_o), 4);
      chk("s5 ignored retry", 32'(retry_cnt), 0);
      sl_tx_transfer_en = 24'h00A0C0 | 24'h100001;
      sl_rx_transfer_en = 24'h00A0C0;
      pulse_phase(0);
      wait_state(8, 50);
      chk("s5 mask kept", 32'(ns_adapter_rstn), 32'h00A0C0);

      // Asynchronous reset in the middle of a run.
      pulse_start(ALL);
      wait_state(2, 50);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("async rst state", 32'(state_o), 0);
      chk("async rst rstn", 32'(ns_adapter_rstn), 0);
      @(negedge clk);
      rst = 1'b0;

`ifdef AIB_CALIB_LINK_MON_EN
      sl_tx_transfer_en = ALL; sl_rx_transfer_en = ALL;
      pulse_start(ALL);
      finish_flow(4, 4);
      sl_rx_transfer_en[3] = 1'b0;
      repeat (2) @(negedge clk);
      sl_rx_transfer_en[3] = 1'b1;
      chk("lm state", 32'(state_o), 1);
      chk("lm calib_done", 32'(calib_done), 0);
      chk("lm relock_cnt", 32'(relock_cnt), 1);
      finish_flow(3, 3);
      chk("lm recal done", 32'(calib_done), 1);
`endif

      for (int k = 0; k < 10; k++) begin
         m = N'($urandom());
         if (k == 4) m = '0;
         rand_run(m, 5000);
         repeat (3) @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/aib_calib_master_seq.md
Name: aib_calib_master_seq

Overview:
- Parametrised, restartable calibration master for an AIB master interface.
- Sequences adapter reset, Avalon configuration, phase adjust, MAC-ready and DCC/DLL lock requests over a per-channel enable mask.
- Watchdog timeouts and bounded retries on every wait state; sticky error code on failure.
- Sits between the top-level bring-up controller and the Avalon config sequencer / AIB channel array.

Parameters:
TOTAL_CHNL_NUM, 24, number of AIB channels.
TIMEOUT_W, 16, width of the watchdog counter.
TIMEOUT_CYCLES, 50000, cycles allowed in any wait state before timeout (must be < 2^TIMEOUT_W).
MAX_RETRIES, 3, retries after a timeout before FAIL (0 = no retry).
RST_HOLD_CYCLES, 8, cycles ns_adapter_rstn is held low in RESET (>=1).

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  pulse; starts calibration from IDLE, DONE or FAIL
abort  in  1  pulse; returns to IDLE from any state
chnl_mask  in  TOTAL_CHNL_NUM  channels to calibrate; latched on accepted start
cfg_start  out  1  one-cycle start to the config sequencer
cfg_done  in  1  config sequencer complete (pulse or level)
phase_start  out  1  one-cycle start of the phase-adjust op
phase_done  in  1  phase adjust complete
i_conf_done  out  1  configuration complete
ns_mac_rdy  out  TOTAL_CHNL_NUM  per-channel MAC ready
ns_adapter_rstn  out  TOTAL_CHNL_NUM  per-channel adapter reset, active-low
ms_rx_dcc_dll_lock_req  out  TOTAL_CHNL_NUM  rx lock request
ms_tx_dcc_dll_lock_req  out  TOTAL_CHNL_NUM  tx lock request
sl_tx_transfer_en  in  TOTAL_CHNL_NUM  slave tx transfer enable
sl_rx_transfer_en  in  TOTAL_CHNL_NUM  slave rx transfer enable
calib_done  out  1  calibration succeeded (level)
calib_err  out  1  calibration failed (level)
err_code  out  3  0 none, 1 cfg timeout, 2 phase timeout, 3 transfer timeout, 4 empty mask
retry_cnt  out  2  retries consumed in the current run (saturates at 3)
state_o  out  4  current state encoding

Behaviour:
- All outputs registered. On rst every output is 0 and the state is IDLE; ns_adapter_rstn=0 holds adapters in reset.
- States: IDLE=0, RESET=1, CFG_WAIT=2, CONF_DONE=3, PHASE_WAIT=4, ASSERT_RDY=5, LOCK_REQ=6, XFER_WAIT=7, DONE=8, FAIL=9.
- start in IDLE/DONE/FAIL latches chnl_mask, clears retry_cnt, err_code, calib_done and calib_err, then enters RESET. start in any other state is ignored.
- If the latched mask is all zero, go to FAIL with err_code=4.
- RESET: ns_adapter_rstn=0 for RST_HOLD_CYCLES cycles, then go to CFG_WAIT.
- CFG_WAIT: cfg_start is high on the first cycle only; ns_adapter_rstn=mask. Go to CONF_DONE on cfg_done.
- CONF_DONE: set i_conf_done=1; next cycle go to PHASE_WAIT.
- PHASE_WAIT: phase_start is high on the first cycle; go to ASSERT_RDY on phase_done.
- ASSERT_RDY: ns_mac_rdy=mask; then go to LOCK_REQ.
- LOCK_REQ: both lock_req=mask; then go to XFER_WAIT.
- XFER_WAIT: go to DONE when (sl_tx_transfer_en & mask)==mask and (sl_rx_transfer_en & mask)==mask. Unmasked channel inputs are don't-care.
- DONE: calib_done=1; mask-driven outputs and i_conf_done stay asserted.
- Unmasked channels always drive 0 on every per-channel output.
- Watchdog:
  - Counter clears on every state entry and increments in CFG_WAIT, PHASE_WAIT and XFER_WAIT.
  - When count==TIMEOUT_CYCLES-1 with the completion condition false, a timeout occurs.
  - On timeout with retry_cnt<MAX_RETRIES: increment retry_cnt, clear i_conf_done/ns_mac_rdy/lock_req, re-enter RESET.
  - Otherwise go to FAIL with err_code set for the failing state.
- Simultaneous completion and timeout in the same cycle: completion wins.
- FAIL: calib_err=1; all per-channel outputs 0; i_conf_done=0.
- abort, or abort together with start: next state IDLE, all outputs cleared exactly as on reset. abort has priority over start.
- Asserting rst mid-run returns to IDLE asynchronously.

Optional Feature:
- Macro: AIB_CALIB_LINK_MON_EN.
- Defined: in DONE, if any masked channel drops sl_tx_transfer_en or sl_rx_transfer_en for 2 consecutive cycles, the block clears calib_done and re-enters RESET. This uses the retry budget; FAIL with err_code=3 when exhausted. Adds output relock_cnt (8 bits, saturating) counting relock events, reset 0.
- Not defined: DONE is terminal until start/abort; input drops are ignored; relock_cnt port absent.

Test Plan:
- start, mask=0xFFFFFF, cfg_done 20 cycles after cfg_start, phase_done after 10, transfer_en all-ones -> calib_done=1, err_code=0, retry_cnt=0, state_o=8.
- mask=0x000005, transfer_en=0x000005 only -> DONE; per-channel outputs read 0x000005.
- TIMEOUT_CYCLES=100, MAX_RETRIES=2, cfg_done never asserted -> 3 cfg_start pulses, retry_cnt=2, calib_err=1, err_code=1, outputs 0.
- cfg_done and watchdog expiry in the same cycle -> CONF_DONE, no retry; abort in XFER_WAIT -> IDLE next cycle, all outputs 0.
- start with mask=0 -> FAIL, err_code=4; start during PHASE_WAIT ignored (retry_cnt and state unchanged).
- AIB_CALIB_LINK_MON_EN: in DONE drop sl_rx_transfer_en[3] for 2 cycles -> calib_done=0, state RESET, relock_cnt=1, recalibration to DONE.
